sum_uart_sequencer: RTL and testbench

Front-end controller for the operand-latch / 4-bit adder / UART-transmit datapath. It debounces three raw push-buttons and issues one-cycle active-low save strobes to the operand latch. On a send request it snapshots the 5-bit sum and sequences the UART transmitter through a 4-byte ASCII frame: tens digit, ones digit, CR, LF. It sits between the board buttons and the latch/UART instances in the top level, replacing direct wiring of save_a_n, save_b_n and uart_tx_en.

---
 rtl/sum_uart_sequencer.sv | 171 +++++++++++++++++
 tb/tb_sum_uart_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sum_uart_sequencer.sv
// Button debouncer plus frame sequencer: issues operand-save strobes and sends the
// latched 5-bit sum to the UART as two ASCII digits followed by CR LF.
module sum_uart_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BUSY_TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_a_n,
    input  logic       key_b_n,
    input  logic       key_send_n,
    input  logic [4:0] sum,
    input  logic       uart_tx_busy,
    output logic       save_a_n,
    output logic       save_b_n,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       frame_busy,
    output logic       timeout_err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t          state, state_nx;
    logic [2:0]      key_raw, key_sync_p0, key_sync_p1, key_db, key_fall;
    logic [DB_W-1:0] db_cnt [3];
    logic [4:0]      sum_q;
    logic [1:0]      char_idx, char_idx_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic            tx_en_nx, frame_busy_nx, timeout_err_nx, capture, advance;
    logic [7:0]      tx_data_nx;

    function automatic logic [7:0] frame_byte(input logic [4:0] s, input logic [1:0] idx);
        logic [1:0] tens;
        logic [4:0] ones;
        if (s >= 5'd30) begin
            tens = 2'd3; ones = s - 5'd30;
        end else if (s >= 5'd20) begin
            tens = 2'd2; ones = s - 5'd20;
        end else if (s >= 5'd10) begin
            tens = 2'd1; ones = s - 5'd10;
        end else begin
            tens = 2'd0; ones = s;
        end
        case (idx)
            2'd0:    frame_byte = 8'h30 + {6'd0, tens};
            2'd1:    frame_byte = 8'h30 + {3'd0, ones};
            2'd2:    frame_byte = 8'h0D;
            default: frame_byte = 8'h0A;
        endcase
    endfunction

    assign key_raw = {key_send_n, key_b_n, key_a_n};

    // Synchronizer stage p0 -> p1, then per-key stability counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_sync_p0 <= '1;
            key_sync_p1 <= '1;
            key_db      <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            key_sync_p0 <= key_raw;
            key_sync_p1 <= key_sync_p0;
            for (int i = 0; i < 3; i++) begin
                if (key_sync_p1[i] != key_db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        key_db[i] <= key_sync_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // High in the cycle whose closing edge moves the debounced level 1 -> 0
    always_comb begin
        for (int i = 0; i < 3; i++)
            key_fall[i] = key_db[i] & ~key_sync_p1[i] & (db_cnt[i] == DB_LAST);
    end

    always_comb begin
        state_nx       = state;
        char_idx_nx    = char_idx;
        to_cnt_nx      = to_cnt;
        tx_en_nx       = 1'b0;
        tx_data_nx     = uart_tx_data;
        frame_busy_nx  = frame_busy;
        timeout_err_nx = timeout_err;
        capture        = 1'b0;
        advance        = 1'b0;
        case (state)
            IDLE: begin
                if (key_fall[2]) begin
                    capture       = 1'b1;
                    char_idx_nx   = 2'd0;
                    frame_busy_nx = 1'b1;
                    state_nx      = SEND;
                end
            end
            SEND: begin
                tx_en_nx   = 1'b1;
                tx_data_nx = frame_byte(sum_q, char_idx);
                to_cnt_nx  = '0;
                state_nx   = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_nx = WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    timeout_err_nx = 1'b1;
                    advance        = 1'b1;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) advance = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // A lost byte advances exactly like an acknowledged one
        if (advance) begin
            if (char_idx == 2'd3) begin
                frame_busy_nx = 1'b0;
                state_nx      = IDLE;
            end else begin
                char_idx_nx = char_idx + 2'd1;
                state_nx    = SEND;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            char_idx     <= 2'd0;
            to_cnt       <= '0;
            save_a_n     <= 1'b1;
            save_b_n     <= 1'b1;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
            frame_busy   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            char_idx     <= char_idx_nx;
            to_cnt       <= to_cnt_nx;
            save_a_n     <= ~key_fall[0];
            save_b_n     <= ~key_fall[1];
            uart_tx_en   <= tx_en_nx;
            uart_tx_data <= tx_data_nx;
            frame_busy   <= frame_busy_nx;
            timeout_err  <= timeout_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) sum_q <= sum;
    end

endmodule

// File: tb/tb_sum_uart_sequencer.sv
// Directed bench for sum_uart_sequencer: debounce, save strobes, frame bytes,
// dropped send presses, busy timeout and mid-frame reset.
module tb_sum_uart_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_a_n = 1'b1, key_b_n = 1'b1, key_send_n = 1'b1;
    logic [4:0] sum = 5'd0;
    logic       uart_tx_busy;
    logic       save_a_n, save_b_n, uart_tx_en, frame_busy, timeout_err;
    logic [7:0] uart_tx_data;

    sum_uart_sequencer #(.DEBOUNCE_CYCLES(4), .BUSY_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .key_a_n(key_a_n), .key_b_n(key_b_n),
        .key_send_n(key_send_n), .sum(sum), .uart_tx_busy(uart_tx_busy),
        .save_a_n(save_a_n), .save_b_n(save_b_n), .uart_tx_en(uart_tx_en),
        .uart_tx_data(uart_tx_data), .frame_busy(frame_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // UART model: busy rises the cycle after the start pulse and lasts 10 cycles
    int   busy_cnt = 0;
    logic model_on = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   busy_cnt <= 0;
        else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
        else if (model_on && uart_tx_en) busy_cnt <= 10;
    end
    assign uart_tx_busy = (busy_cnt != 0);

    logic [7:0] txb [0:255];
    int tx_total = 0, a_low = 0, b_low = 0, ab_low = 0, a_last = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (uart_tx_en && tx_total < 256) begin
            txb[tx_total] <= uart_tx_data;
            tx_total      <= tx_total + 1;
        end
        if (!save_a_n) begin
            a_low  <= a_low + 1;
            a_last <= cyc;
        end
        if (!save_b_n) b_low <= b_low + 1;
        if (!save_a_n && !save_b_n) ab_low <= ab_low + 1;
    end

    int checks = 0, errors = 0, t_press = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // which: 0=A 1=B 2=send 3=A+B together
    task automatic press(input int which, input int len);
        @(negedge clk);
        case (which)
            0: key_a_n = 1'b0;
            1: key_b_n = 1'b0;
            2: key_send_n = 1'b0;
            default: begin key_a_n = 1'b0; key_b_n = 1'b0; end
        endcase
        t_press = cyc;
        repeat (len) @(negedge clk);
        key_a_n = 1'b1; key_b_n = 1'b1; key_send_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_frame(input string nm);
        int n;
        n = 0;
        while (!frame_busy && n < 40) begin @(negedge clk); n++; end
        while (frame_busy && n < 700) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk({nm, "_frame_end"}, frame_busy, 1'b0);
    endtask

    task automatic chk_frame(input string nm, input int base, input logic [7:0] t, input logic [7:0] o);
        chk({nm, "_pulses"}, tx_total - base, 4);
        chk({nm, "_b0"}, txb[base], t);
        chk({nm, "_b1"}, txb[base+1], o);
        chk({nm, "_b2"}, txb[base+2], 8'h0D);
        chk({nm, "_b3"}, txb[base+3], 8'h0A);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_save_a_n"}, save_a_n, 1'b1);
        chk({nm, "_save_b_n"}, save_b_n, 1'b1);
        chk({nm, "_tx_en"}, uart_tx_en, 1'b0);
        chk({nm, "_tx_data"}, uart_tx_data, 8'h00);
        chk({nm, "_frame_busy"}, frame_busy, 1'b0);
        chk({nm, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    typedef struct {
        logic [4:0] s;
        logic [7:0] tens;
        logic [7:0] ones;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int base, a0, b0, ab0;
        vecs[0] = '{5'd17, 8'h31, 8'h37};
        vecs[1] = '{5'd0,  8'h30, 8'h30};
        vecs[2] = '{5'd30, 8'h33, 8'h30};
        vecs[3] = '{5'd5,  8'h30, 8'h35};
        vecs[4] = '{5'd31, 8'h33, 8'h31};
        vecs[5] = '{5'd29, 8'h32, 8'h39};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Short glitch must not produce a strobe
        a0 = a_low;
        press(0, 3);
        chk("glitch_no_strobe", a_low - a0, 0);

        // Valid press: one single-cycle strobe a few cycles after the edge
        a0 = a_low;
        press(0, 10);
        chk("press_a_one_cycle", a_low - a0, 1);
        chk("press_a_latency", ((a_last - t_press) >= 5) && ((a_last - t_press) <= 8), 1'b1);

        a0 = a_low; b0 = b_low; ab0 = ab_low;
        press(3, 10);
        chk("ab_a_strobe", a_low - a0, 1);
        chk("ab_b_strobe", b_low - b0, 1);
        chk("ab_same_cycle", ab_low - ab0, 1);

        model_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sum  = vecs[i].s;
            base = tx_total;
            press(2, 8);
            wait_frame($sformatf("vec%0d", i));
            chk_frame($sformatf("vec%0d", i), base, vecs[i].tens, vecs[i].ones);
        end
        chk("tx_data_holds", uart_tx_data, 8'h0A);
        chk("no_timeout_with_uart", timeout_err, 1'b0);

        // Sum change and a second send press during a frame
        sum  = 5'd30;
        base = tx_total;
        press(2, 8);
        chk("midframe_busy", frame_busy, 1'b1);
        sum = 5'd9;
        press(2, 8);
        wait_frame("midframe");
        repeat (100) @(negedge clk);
        chk_frame("midframe", base, 8'h33, 8'h30);
        chk("no_followon_busy", frame_busy, 1'b0);

        // UART never answers: each byte times out, frame still completes
        model_on = 1'b0;
        sum  = 5'd12;
        base = tx_total;
        press(2, 8);
        wait_frame("timeout");
        chk("timeout_err_set", timeout_err, 1'b1);
        chk_frame("timeout", base, 8'h31, 8'h32);

        // Reset in the middle of a frame
        press(2, 8);
        chk("sticky_err", timeout_err, 1'b1);
        chk("second_frame_busy", frame_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        base = tx_total;
        repeat (60) @(negedge clk);
        chk("no_retry_pulses", tx_total - base, 0);
        chk("no_retry_busy", frame_busy, 1'b0);
        chk("err_stays_clear", timeout_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
